// File: rtl/lap_mesh_mm.sv
// lap_mesh_mm
//   Output-stationary systolic mesh of XMAX x YMAX signed multiply-accumulate PEs
//   with its own run-control FSM. One run computes C = A*B for one output tile over
//   an inner dimension of k_len (clamped to KMAX). C is then unloaded serially in
//   row-major order.
//
// Ports
//   clk, reset          single rising-edge clock, synchronous active-high reset
//   start, k_len        begin a run (honoured in IDLE only); k_len latched with it
//   in_valid/in_ready   k-slice input handshake; a_in = column k of A,
//                       b_in = row k of B
//   out_valid/out_ready result handshake; out_data = C[out_row][out_col]
//   busy                FSM not IDLE
//   done                one-cycle pulse, the cycle after the last element is taken
//   cycles              length of the last run, saturating
//   state_dbg           current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
//   high. The producer keeps valid and its data stable until that edge; ready
//   never depends combinationally on valid.
module lap_mesh_mm #(
  parameter int XMAX = 3,
  parameter int YMAX = 3,
  parameter int KMAX = 16,
  parameter int DW   = 8,
  parameter int AW   = 2*DW + $clog2(KMAX+1),
  localparam int KW  = $clog2(KMAX+1),
  localparam int RW  = (XMAX > 1) ? $clog2(XMAX) : 1,
  localparam int CW  = (YMAX > 1) ? $clog2(YMAX) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KW-1:0]      k_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XMAX*DW-1:0] a_in,
  input  logic [YMAX*DW-1:0] b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AW-1:0]      out_data,
  output logic [RW-1:0]      out_row,
  output logic [CW-1:0]      out_col,
  output logic               busy,
  output logic               done,
  output logic [31:0]        cycles,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_UNLOAD = 2'd3;

  localparam int DCW = $clog2(XMAX+YMAX);
  localparam logic [DCW-1:0] D_LAST   = DCW'(XMAX+YMAX-2);
  localparam logic [KW-1:0]  K_MAX_V  = KW'(KMAX);
  localparam logic [RW-1:0]  ROW_LAST = RW'(XMAX-1);
  localparam logic [CW-1:0]  COL_LAST = CW'(YMAX-1);

  logic [1:0]     state;
  logic [KW-1:0]  k_lat;
  logic [KW-1:0]  beat_cnt;
  logic [DCW-1:0] drain_cnt;
  logic [31:0]    run_cnt;
  logic [31:0]    run_cnt_inc;
  logic [KW-1:0]  k_eff;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic           beat;
  logic           last_el;
  logic           run_start;

  assign in_ready    = (state == S_LOAD);
  assign out_valid   = (state == S_UNLOAD);
  assign busy        = (state != S_IDLE);
  assign state_dbg   = state;
  assign beat        = in_valid && in_ready;
  assign run_start   = (state == S_IDLE) && start;
  assign k_eff       = (k_len > K_MAX_V) ? K_MAX_V : k_len;
  assign run_cnt_inc = (run_cnt == '1) ? run_cnt : run_cnt + 32'd1;
  assign last_el     = (row == ROW_LAST) && (col == COL_LAST);
  assign out_row     = row;
  assign out_col     = col;

  // ---------------------------------------------------------------- run control
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      k_lat     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      run_cnt   <= '0;
      cycles    <= '0;
      row       <= '0;
      col       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            k_lat    <= k_eff;
            beat_cnt <= '0;
            run_cnt  <= '0;
            row      <= '0;
            col      <= '0;
            // An empty inner dimension leaves every result at zero, so there
            // is nothing to load or drain.
            state    <= (k_eff == '0) ? S_UNLOAD : S_LOAD;
          end
        end
        S_LOAD: begin
          run_cnt <= run_cnt_inc;
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt + 1'b1 == k_lat) begin
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The last slice needs XMAX+YMAX-2 hops to reach the far corner PE.
          run_cnt <= run_cnt_inc;
          if (drain_cnt == D_LAST) begin
            state <= S_UNLOAD;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_UNLOAD: begin
          run_cnt <= run_cnt_inc;
          if (out_ready) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row <= '0;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
            if (last_el) begin
              cycles <= run_cnt_inc;
              done   <= 1'b1;
              state  <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- input skew
  // Row i of A and column j of B are delayed i and j cycles so that matching
  // k-slices meet inside each PE. Each operand carries its beat tag along.
  logic [DW-1:0] a_sk  [XMAX];
  logic          a_skv [XMAX];
  logic [DW-1:0] b_sk  [YMAX];
  logic          b_skv [YMAX];

  for (genvar i = 0; i < XMAX; i++) begin : g_askew
    if (i == 0) begin : g_d0
      assign a_sk[i]  = a_in[i*DW +: DW];
      assign a_skv[i] = beat;
    end else begin : g_dn
      logic [DW-1:0] sh  [i];
      logic          shv [i];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int d = 0; d < i; d++) begin
            sh[d]  <= '0;
            shv[d] <= 1'b0;
          end
        end else begin
          sh[0]  <= a_in[i*DW +: DW];
          shv[0] <= beat;
          for (int d = 1; d < i; d++) begin
            sh[d]  <= sh[d-1];
            shv[d] <= shv[d-1];
          end
        end
      end
      assign a_sk[i]  = sh[i-1];
      assign a_skv[i] = shv[i-1];
    end
  end

  for (genvar j = 0; j < YMAX; j++) begin : g_bskew
    if (j == 0) begin : g_d0
      assign b_sk[j]  = b_in[j*DW +: DW];
      assign b_skv[j] = beat;
    end else begin : g_dn
      logic [DW-1:0] sh  [j];
      logic          shv [j];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int d = 0; d < j; d++) begin
            sh[d]  <= '0;
            shv[d] <= 1'b0;
          end
        end else begin
          sh[0]  <= b_in[j*DW +: DW];
          shv[0] <= beat;
          for (int d = 1; d < j; d++) begin
            sh[d]  <= sh[d-1];
            shv[d] <= shv[d-1];
          end
        end
      end
      assign b_sk[j]  = sh[j-1];
      assign b_skv[j] = shv[j-1];
    end
  end

  // ---------------------------------------------------------------- PE mesh
  // a_w/b_w are the operands arriving at PE(i,j); a_q/b_q are the registered
  // copies each PE hands to its right/lower neighbour.
  logic [DW-1:0]          a_w   [XMAX][YMAX];
  logic                   a_wv  [XMAX][YMAX];
  logic [DW-1:0]          b_w   [XMAX][YMAX];
  logic                   b_wv  [XMAX][YMAX];
  logic [DW-1:0]          a_q   [XMAX][YMAX];
  logic                   a_qv  [XMAX][YMAX];
  logic [DW-1:0]          b_q   [XMAX][YMAX];
  logic                   b_qv  [XMAX][YMAX];
  logic signed [2*DW-1:0] prod  [XMAX][YMAX];
  logic signed [AW-1:0]   acc   [XMAX][YMAX];

  for (genvar i = 0; i < XMAX; i++) begin : g_row
    for (genvar j = 0; j < YMAX; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_w[i][j]  = a_sk[i];
        assign a_wv[i][j] = a_skv[i];
      end else begin : g_a_hop
        assign a_w[i][j]  = a_q[i][j-1];
        assign a_wv[i][j] = a_qv[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_w[i][j]  = b_sk[j];
        assign b_wv[i][j] = b_skv[j];
      end else begin : g_b_hop
        assign b_w[i][j]  = b_q[i-1][j];
        assign b_wv[i][j] = b_qv[i-1][j];
      end
      assign prod[i][j] = $signed(a_w[i][j]) * $signed(b_w[i][j]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < XMAX; i++) begin
        for (int j = 0; j < YMAX; j++) begin
          a_q[i][j]  <= '0;
          a_qv[i][j] <= 1'b0;
          b_q[i][j]  <= '0;
          b_qv[i][j] <= 1'b0;
          acc[i][j]  <= '0;
        end
      end
    end else begin
      for (int i = 0; i < XMAX; i++) begin
        for (int j = 0; j < YMAX; j++) begin
          a_q[i][j]  <= a_w[i][j];
          a_qv[i][j] <= a_wv[i][j];
          b_q[i][j]  <= b_w[i][j];
          b_qv[i][j] <= b_wv[i][j];
          if (run_start) begin
            acc[i][j] <= '0;
          end else if (a_wv[i][j] && b_wv[i][j]) begin
            // Sign-extended product; the sum wraps modulo 2^AW.
            acc[i][j] <= acc[i][j] + {{(AW-2*DW){prod[i][j][2*DW-1]}}, prod[i][j]};
          end
        end
      end
    end
  end

  assign out_data = acc[row][col];

endmodule

// File: tb/tb_lap_mesh_mm.sv
// tb_lap_mesh_mm
//   Bench for lap_mesh_mm on a 2x2 mesh with KMAX=16. The reference computes each
//   C element as a plain sum of products and a cycle-level phase plan
//   (load length from the driven in_valid pattern, fixed drain, unload paced by
//   out_ready) that predicts every handshake output and the run length.
module tb_lap_mesh_mm;

  localparam int XMAX  = 2;
  localparam int YMAX  = 2;
  localparam int KMAX  = 16;
  localparam int DW    = 8;
  localparam int AW    = 2*DW + $clog2(KMAX+1);
  localparam int KW    = $clog2(KMAX+1);
  localparam int RW    = 1;
  localparam int CW    = 1;
  localparam int NEL   = XMAX*YMAX;
  localparam int DRAIN = XMAX+YMAX-1;
  localparam int AINW  = XMAX*DW;
  localparam int BINW  = YMAX*DW;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [KW-1:0]      k_len;
  logic               in_valid;
  logic               in_ready;
  logic [AINW-1:0]    a_in;
  logic [BINW-1:0]    b_in;
  logic               out_valid;
  logic               out_ready;
  logic [AW-1:0]      out_data;
  logic [RW-1:0]      out_row;
  logic [CW-1:0]      out_col;
  logic               busy;
  logic               done;
  logic [31:0]        cycles;
  logic [1:0]         state_dbg;

  lap_mesh_mm #(.XMAX(XMAX), .YMAX(YMAX), .KMAX(KMAX), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .busy(busy), .done(done),
    .cycles(cycles), .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [AW-1:0] exp_q[$];

  int job_a [KMAX][XMAX];
  int job_b [KMAX][YMAX];
  int job_klen;
  int job_k;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void build_expect();
    exp_q.delete();
    for (int i = 0; i < XMAX; i++) begin
      for (int j = 0; j < YMAX; j++) begin
        longint s;
        logic [AW-1:0] e;
        s = 0;
        for (int k = 0; k < job_k; k++) s += longint'(job_a[k][i]) * longint'(job_b[k][j]);
        e = s[AW-1:0];
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic void set_klen(input int kl);
    job_klen = kl;
    job_k    = (kl > KMAX) ? KMAX : kl;
  endfunction

  function automatic void gen_job(input int kl);
    set_klen(kl);
    for (int k = 0; k < KMAX; k++) begin
      for (int i = 0; i < XMAX; i++) job_a[k][i] = int'($urandom_range(0, 255)) - 128;
      for (int j = 0; j < YMAX; j++) job_b[k][j] = int'($urandom_range(0, 255)) - 128;
    end
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic drive_slice(input int k);
    for (int i = 0; i < XMAX; i++) a_in[i*DW +: DW] = DW'(job_a[k][i]);
    for (int j = 0; j < YMAX; j++) b_in[j*DW +: DW] = DW'(job_b[k][j]);
  endtask

  // iv_mode: 0 in_valid always 1, 1 toggling 1,0,1,..., 2 random
  // or_mode: 0 out_ready always 1, 1 random, 2 held low 5 cycles on element 1
  // noise:   pulse start at random while the run is busy
  // started: start for this job was already driven in the previous done cycle
  // chain:   drive start (k_len = next_klen) in this job's done cycle
  task automatic run_job(input int iv_mode, input int or_mode, input bit noise,
                         input bit started, input bit chain, input int next_klen);
    int t, beats, idx, load_end, unload_start, last_t, stall;
    bit fin, in_load, in_unl, v, r;
    build_expect();
    if (!started) begin
      @(negedge clk);
      start = 1'b1;
      k_len = KW'(job_klen);
    end
    t = 0; beats = 0; idx = 0; stall = 0; last_t = -1; fin = 1'b0;
    load_end     = (job_k == 0) ? 0 : -1;
    unload_start = (job_k == 0) ? 1 : -1;
    while (!fin) begin
      @(negedge clk);
      t++;
      start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      k_len = KW'($urandom_range(0, 31));
      if (t > 2000) begin
        check_val("run_timeout", 32'(t), 32'd2000);
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        fin = 1'b1;
      end else if (last_t >= 0 && t == last_t + 1) begin
        check_val("done_pulse", 32'(done), 32'd1);
        check_val("done_busy", 32'(busy), 32'd0);
        check_val("done_out_valid", 32'(out_valid), 32'd0);
        check_val("done_in_ready", 32'(in_ready), 32'd0);
        check_val("cycles", cycles, 32'(last_t));
        start = chain;
        if (chain) k_len = KW'(next_klen);
        in_valid = 1'b0;
        out_ready = 1'b0;
        fin = 1'b1;
      end else begin
        in_load = (job_k > 0) && (load_end < 0);
        in_unl  = (unload_start > 0) && (t >= unload_start);
        check_val("in_ready", 32'(in_ready), 32'(in_load));
        check_val("out_valid", 32'(out_valid), 32'(in_unl));
        check_val("busy", 32'(busy), 32'd1);
        check_val("done_low", 32'(done), 32'd0);
        if (in_load) begin
          case (iv_mode)
            0:       v = 1'b1;
            1:       v = (t % 2 == 1);
            default: v = ($urandom_range(0, 1) == 1);
          endcase
          in_valid = v;
          if (v) begin
            drive_slice(beats);
            beats++;
            if (beats == job_k) begin
              load_end = t;
              unload_start = t + DRAIN + 1;
            end
          end else begin
            a_in = AINW'($urandom());
            b_in = BINW'($urandom());
          end
        end else begin
          // Anything offered outside LOAD must be ignored.
          in_valid = ($urandom_range(0, 1) == 1);
          a_in = AINW'($urandom());
          b_in = BINW'($urandom());
        end
        if (in_unl && exp_q.size() > 0) begin
          check_val("out_data", 32'(out_data), 32'(exp_q[0]));
          check_val("out_row", 32'(out_row), 32'(idx / YMAX));
          check_val("out_col", 32'(out_col), 32'(idx % YMAX));
          case (or_mode)
            0:       r = 1'b1;
            1:       r = ($urandom_range(0, 2) != 0);
            default: begin
              r = !(idx == 1 && stall < 5);
              if (idx == 1 && stall < 5) stall++;
            end
          endcase
          out_ready = r;
          if (r) begin
            void'(exp_q.pop_front());
            idx++;
            if (idx == NEL) last_t = t;
          end
        end else begin
          out_ready = ($urandom_range(0, 1) == 1);
        end
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic load_example();
    set_klen(2);
    // A = [[1,2],[3,4]] (column k feeds a_in), B = [[5,6],[7,8]] (row k feeds b_in)
    job_a[0][0] = 1; job_a[0][1] = 3;
    job_a[1][0] = 2; job_a[1][1] = 4;
    job_b[0][0] = 5; job_b[0][1] = 6;
    job_b[1][0] = 7; job_b[1][1] = 8;
  endtask

  // ---------------------------------------------------------------- main sequence
  initial begin
    int nk;
    bit st, ch;
    reset = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    a_in = '0; b_in = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check_val("reset_out_data", 32'(out_data), 32'd0);
    check_val("reset_out_row", 32'(out_row), 32'd0);
    check_val("reset_out_col", 32'(out_col), 32'd0);
    check_val("reset_cycles", cycles, 32'd0);
    reset = 1'b0;

    // Worked example, no stalls: 19,22,43,50 and cycles = 2+3+4.
    load_example();
    run_job(0, 0, 1'b0, 1'b0, 1'b0, 0);
    // in_valid toggling 1,0,1
    run_job(1, 0, 1'b0, 1'b0, 1'b0, 0);
    // out_ready held low for 5 cycles on element (0,1)
    run_job(0, 2, 1'b0, 1'b0, 1'b0, 0);
    // Empty inner dimension: zeros, straight to unload
    gen_job(0);
    run_job(0, 0, 1'b0, 1'b0, 1'b0, 0);

    // Full length with most-negative operands, start noise while busy
    set_klen(KMAX);
    for (int k = 0; k < KMAX; k++) begin
      for (int i = 0; i < XMAX; i++) job_a[k][i] = -128;
      for (int j = 0; j < YMAX; j++) job_b[k][j] = -128;
    end
    run_job(0, 1, 1'b1, 1'b0, 1'b0, 0);
    // k_len above KMAX clamps
    gen_job(KMAX + 4);
    run_job(2, 1, 1'b0, 1'b0, 1'b0, 0);

    // Reset during DRAIN aborts the run without a done pulse
    load_example();
    @(negedge clk);
    start = 1'b1; k_len = KW'(2);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; drive_slice(k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("abort");
    check_val("abort_cycles", cycles, 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_idle("after_abort");
    end
    run_job(0, 0, 1'b0, 1'b0, 1'b0, 0);

    // start in the done cycle launches the next run back-to-back
    load_example();
    run_job(0, 0, 1'b0, 1'b0, 1'b1, 2);
    run_job(1, 1, 1'b0, 1'b1, 1'b0, 0);

    // Random runs, some chained through the done cycle
    st = 1'b0;
    nk = $urandom_range(0, KMAX + 3);
    for (int n = 0; n < 12; n++) begin
      gen_job(nk);
      nk = $urandom_range(0, KMAX + 3);
      ch = ($urandom_range(0, 1) == 1);
      run_job($urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 1) == 1), st, ch, nk);
      st = ch;
    end
    if (st) begin
      gen_job(nk);
      run_job(2, 1, 1'b0, 1'b1, 1'b0, 0);
    end

    @(negedge clk);
    check_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
